// File: rtl/alu_serial_rx_if.sv
// ============================================================================
// Module      : alu_serial_rx_if
// Description : Decoded-packet result bus from the serial receiver to the ALU core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_serial_rx_if;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [2:0]  op_o;
    logic        valid_o;
    logic        err_o;
    logic [2:0]  err_flags_o;

    modport master (
        output a_o, b_o, op_o, valid_o, err_o, err_flags_o
    );

    modport slave (
        input a_o, b_o, op_o, valid_o, err_o, err_flags_o
    );
endinterface

`default_nettype wire

// File: rtl/alu_serial_rx.sv
// ============================================================================
// Module      : alu_serial_rx
// Description : Deserializes ALU command frames and presents A/B/OP with error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial_rx #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        sin,
    alu_serial_rx_if.master  res
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TYPE = 2'd1,
        S_BITS = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              type_q, type_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic              stop_err_q, stop_err_d;
    logic [63:0]       data_q, data_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [2:0]        flags_q, flags_d;
    logic [3:0]        crc_calc;

    // x^4+x+1, init 0, over the 68-bit string MSB first
    function automatic logic [3:0] crc4(input logic [67:0] m);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ m[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    // data_q holds {B, A}; the CMD byte sits in shift_q while in STOP
    assign crc_calc = crc4({data_q, 1'b1, shift_q[6:4]});

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        type_d     = type_q;
        byte_cnt_d = byte_cnt_q;
        stop_err_d = stop_err_q;
        data_d     = data_q;
        to_cnt_d   = '0;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        flags_d    = flags_q;

        case (state_q)
            S_IDLE: begin
                if (!sin) begin
                    state_d = S_TYPE;
                end else if ((TIMEOUT_CYCLES != 0) && (byte_cnt_q != 4'd0)) begin
                    if (to_cnt_q == TO_LAST) begin
                        byte_cnt_d = 4'd0;
                        stop_err_d = 1'b0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            S_TYPE: begin
                type_d    = sin;
                bit_cnt_d = 3'd0;
                state_d   = S_BITS;
            end
            S_BITS: begin
                shift_d   = {shift_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                state_d = S_IDLE;
                if (!type_q) begin
                    for (int s = 0; s < 8; s++) begin
                        if (byte_cnt_q == 4'(s)) begin
                            data_d[63 - 8*s -: 8] = shift_q;
                        end
                    end
                    if (byte_cnt_q != 4'd9) begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                    if (!sin) begin
                        stop_err_d = 1'b1;
                    end
                end else begin
                    valid_d    = 1'b1;
                    byte_cnt_d = 4'd0;
                    stop_err_d = 1'b0;
                    if ((byte_cnt_q != 4'd8) || stop_err_q || !sin) begin
                        err_d   = 1'b1;
                        flags_d = 3'b100;
                    end else if (crc_calc != shift_q[3:0]) begin
                        err_d   = 1'b1;
                        flags_d = 3'b010;
                    end else if (shift_q[5]) begin
                        // legal opcodes 000/001/100/101 all have bit1 clear
                        err_d   = 1'b1;
                        flags_d = 3'b001;
                    end else begin
                        a_d     = data_q[31:0];
                        b_d     = data_q[63:32];
                        op_d    = shift_q[6:4];
                        err_d   = 1'b0;
                        flags_d = 3'b000;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            type_q     <= 1'b0;
            byte_cnt_q <= 4'd0;
            stop_err_q <= 1'b0;
            data_q     <= 64'd0;
            to_cnt_q   <= '0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            op_q       <= 3'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            flags_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            type_q     <= type_d;
            byte_cnt_q <= byte_cnt_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            to_cnt_q   <= to_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            flags_q    <= flags_d;
        end
    end

    assign res.a_o         = a_q;
    assign res.b_o         = b_q;
    assign res.op_o        = op_q;
    assign res.valid_o     = valid_q;
    assign res.err_o       = err_q;
    assign res.err_flags_o = flags_q;

endmodule

`default_nettype wire
